reorder_buffer: RTL

In-order retirement queue of the out-of-order core. Allocates one entry per decoded instruction and hands the entry's ROB id to the register file's rename table. Captures results broadcast by execution units, retires entries strictly in program order, and drives the register-file commit port (value write plus rename clear). Detects branch mispredictions at the head and issues a one-cycle roll-back that flushes itself, the register file's rename state, and downstream stations.

---
 rtl/reorder_buffer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates entries at decode, captures CDB results,
// retires strictly in program order and flushes everything on a head mispredict.
module reorder_buffer #(
    parameter int ROB_SIZE = 16,
    parameter int ID_W     = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            ID_valid,
    input  logic            ID_rd_valid,
    input  logic [4:0]      ID_rd,
    input  logic            ID_is_branch,
    input  logic            ID_is_store,
    input  logic            ID_pred_taken,
    input  logic [31:0]     ID_pc,
    output logic            ROB_full,
    output logic [ID_W-1:0] ROB_alloc_id,
    input  logic            CDB_valid,
    input  logic [ID_W-1:0] CDB_ROB_id,
    input  logic [31:0]     CDB_value,
    input  logic            CDB_taken,
    input  logic [31:0]     CDB_target,
    output logic            RF_input_valid,
    output logic [4:0]      RF_rd,
    output logic [31:0]     RF_value,
    output logic [ID_W-1:0] RF_commit_ROB_id,
    output logic            LSB_store_commit,
    output logic [ID_W-1:0] LSB_store_ROB_id,
    output logic            ROB_roll_back_flag,
    output logic [31:0]     ROB_roll_back_pc
);

    logic [ROB_SIZE-1:0] busy;
    logic [ROB_SIZE-1:0] ready;
    logic [ROB_SIZE-1:0] rd_valid;
    logic [ROB_SIZE-1:0] is_branch;
    logic [ROB_SIZE-1:0] is_store;
    logic [ROB_SIZE-1:0] pred_taken;
    logic [ROB_SIZE-1:0] taken;
    logic [4:0]          rd     [ROB_SIZE];
    logic [31:0]         value  [ROB_SIZE];
    logic [31:0]         pc     [ROB_SIZE];
    logic [31:0]         target [ROB_SIZE];

    logic [ID_W-1:0] head;
    logic [ID_W-1:0] tail;
    logic [ID_W:0]   count;

    logic commit_fire;
    logic mispredict;
    logic issue_fire;
    logic wb_fire;

    assign ROB_alloc_id = tail;
    assign ROB_full     = (count == (ID_W+1)'(ROB_SIZE));

    // A mispredict at the head discards any issue or writeback in the same cycle.
    // Issue while full is only accepted when the head retires on the same edge.
    always_comb begin
        commit_fire = rdy && busy[head] && ready[head];
        mispredict  = commit_fire && is_branch[head] && (taken[head] != pred_taken[head]);
        issue_fire  = rdy && ID_valid && (!ROB_full || commit_fire) && !mispredict;
        wb_fire     = rdy && CDB_valid && busy[CDB_ROB_id] && !mispredict;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            busy       <= '0;
            ready      <= '0;
            rd_valid   <= '0;
            is_branch  <= '0;
            is_store   <= '0;
            pred_taken <= '0;
            taken      <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                rd[i]     <= '0;
                value[i]  <= '0;
                pc[i]     <= '0;
                target[i] <= '0;
            end
        end else if (rdy) begin
            if (mispredict) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                busy  <= '0;
                ready <= '0;
            end else begin
                if (wb_fire) begin
                    ready[CDB_ROB_id]  <= 1'b1;
                    value[CDB_ROB_id]  <= CDB_value;
                    taken[CDB_ROB_id]  <= CDB_taken;
                    target[CDB_ROB_id] <= CDB_target;
                end
                if (commit_fire) begin
                    busy[head]  <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= head + ID_W'(1);
                end
                // Written last so that, when full, the slot freed by commit is refilled.
                if (issue_fire) begin
                    busy[tail]       <= 1'b1;
                    ready[tail]      <= 1'b0;
                    rd_valid[tail]   <= ID_rd_valid;
                    rd[tail]         <= ID_rd;
                    is_branch[tail]  <= ID_is_branch;
                    is_store[tail]   <= ID_is_store;
                    pred_taken[tail] <= ID_pred_taken;
                    pc[tail]         <= ID_pc;
                    tail             <= tail + ID_W'(1);
                end
                case ({issue_fire, commit_fire})
                    2'b10:   count <= count + (ID_W+1)'(1);
                    2'b01:   count <= count - (ID_W+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            RF_input_valid     <= 1'b0;
            RF_rd              <= '0;
            RF_value           <= '0;
            RF_commit_ROB_id   <= '0;
            LSB_store_commit   <= 1'b0;
            LSB_store_ROB_id   <= '0;
            ROB_roll_back_flag <= 1'b0;
            ROB_roll_back_pc   <= '0;
        end else begin
            RF_input_valid     <= 1'b0;
            LSB_store_commit   <= 1'b0;
            ROB_roll_back_flag <= 1'b0;
            if (commit_fire) begin
                RF_commit_ROB_id <= head;
                if (!is_branch[head] && rd_valid[head] && (rd[head] != 5'd0)) begin
                    RF_input_valid <= 1'b1;
                    RF_rd          <= rd[head];
                    RF_value       <= value[head];
                end
                if (is_store[head]) begin
                    LSB_store_commit <= 1'b1;
                    LSB_store_ROB_id <= head;
                end
                if (mispredict) begin
                    ROB_roll_back_flag <= 1'b1;
                    ROB_roll_back_pc   <= taken[head] ? target[head] : pc[head] + 32'd4;
                end
            end
        end
    end

endmodule
